// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding,
// array write modes and the default line geometry.
package icache_pkg;

  localparam int ICACHE_WORD_SIZE  = 16;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_NUM_LINES  = 8;

  // Two-bit controller state encoding.
  typedef enum logic [1:0] {
    ICACHE_IDLE  = 2'd0,
    ICACHE_FILL  = 2'd1,
    ICACHE_WRITE = 2'd2,
    ICACHE_RESP  = 2'd3
  } icache_state_e;

  // Write-port operation of the storage array.
  typedef enum logic [1:0] {
    ARR_WR_NONE = 2'd0,
    ARR_WR_LINE = 2'd1,
    ARR_WR_WORD = 2'd2
  } arr_wr_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational lookup port; one synchronous write port that either installs
// a whole line (tag + valid set) or patches a single word keeping the tag.
module icache_array
  import icache_pkg::*;
#(
  parameter int WORD_SIZE  = ICACHE_WORD_SIZE,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES,
  parameter int OFF_BITS   = $clog2(LINE_WORDS),
  parameter int IDX_BITS   = $clog2(NUM_LINES),
  parameter int TAG_BITS   = WORD_SIZE - IDX_BITS - OFF_BITS
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [IDX_BITS-1:0]              rd_idx,
  output logic                             rd_valid,
  output logic [TAG_BITS-1:0]              rd_tag,
  output logic [LINE_WORDS*WORD_SIZE-1:0]  rd_line,
  input  arr_wr_e                          wr_mode,
  input  logic [IDX_BITS-1:0]              wr_idx,
  input  logic [OFF_BITS-1:0]              wr_off,
  input  logic [TAG_BITS-1:0]              wr_tag,
  input  logic [LINE_WORDS*WORD_SIZE-1:0]  wr_line,
  input  logic [WORD_SIZE-1:0]             wr_word
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_mem [NUM_LINES];

  // A line becomes valid only when it is installed in full.
  always_comb begin
    valid_d = valid_q;
    if (wr_mode == ARR_WR_LINE) valid_d[wr_idx] = 1'b1;
  end

  // Valid bits are the only state cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // Tags change only on a full-line install.
  always_ff @(posedge clk) begin
    if (wr_mode == ARR_WR_LINE) tag_mem[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];

  // One storage column per word of the line so a single-word update never
  // touches its neighbours.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [WORD_SIZE-1:0] word_mem [NUM_LINES];

      // Column write: whole-line install or targeted word patch.
      always_ff @(posedge clk) begin
        if (wr_mode == ARR_WR_LINE)
          word_mem[wr_idx] <= wr_line[gi*WORD_SIZE +: WORD_SIZE];
        else if (wr_mode == ARR_WR_WORD && wr_off == OFF_BITS'(gi))
          word_mem[wr_idx] <= wr_word;
      end

      assign rd_line[gi*WORD_SIZE +: WORD_SIZE] = word_mem[rd_idx];
    end
  endgenerate

endmodule

// File: rtl/icache.sv
// Direct-mapped, write-through, no-write-allocate instruction cache.
// Hits answer from the local array; read misses fetch a full line; every
// write goes through to memory and patches the cached word only on a hit.
// Optional feature: define ICACHE_STATS_EN to add the num_hit/num_miss
// counters and their ports.
module icache
  import icache_pkg::*;
#(
  parameter int WORD_SIZE  = ICACHE_WORD_SIZE,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             i_readM,
  input  logic                             i_writeM,
  input  logic [WORD_SIZE-1:0]             i_address,
  inout  wire  [WORD_SIZE-1:0]             i_data,
  output logic                             i_ready,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [WORD_SIZE-1:0]             mem_address,
  output logic [WORD_SIZE-1:0]             mem_wdata,
  input  logic [LINE_WORDS*WORD_SIZE-1:0]  mem_rdata,
  input  logic                             mem_ready
`ifdef ICACHE_STATS_EN
  ,
  output logic [WORD_SIZE-1:0]             num_hit,
  output logic [WORD_SIZE-1:0]             num_miss
`endif
);

  localparam int OFF = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TAG = WORD_SIZE - IDX - OFF;

  icache_state_e        state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 rd_q, rd_d;
  logic [WORD_SIZE-1:0] word_q, word_d;

  // Address fields of the incoming request and of the latched request.
  logic [OFF-1:0] in_off, q_off;
  logic [IDX-1:0] in_idx, q_idx;
  logic [TAG-1:0] in_tag, q_tag;

  assign in_off = i_address[OFF-1:0];
  assign in_idx = i_address[OFF +: IDX];
  assign in_tag = i_address[WORD_SIZE-1 -: TAG];
  assign q_off  = addr_q[OFF-1:0];
  assign q_idx  = addr_q[OFF +: IDX];
  assign q_tag  = addr_q[WORD_SIZE-1 -: TAG];

  logic                            arr_valid;
  logic [TAG-1:0]                  arr_tag;
  logic [LINE_WORDS*WORD_SIZE-1:0] arr_line;
  arr_wr_e                         wr_mode;
  logic [IDX-1:0]                  wr_idx;
  logic [OFF-1:0]                  wr_off;
  logic [WORD_SIZE-1:0]            wr_word;
  logic                            hit;

  // Lookup always uses the live cpu address; it only matters in IDLE.
  icache_array #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .OFF_BITS  (OFF),
    .IDX_BITS  (IDX),
    .TAG_BITS  (TAG)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_idx  (in_idx),
    .rd_valid(arr_valid),
    .rd_tag  (arr_tag),
    .rd_line (arr_line),
    .wr_mode (wr_mode),
    .wr_idx  (wr_idx),
    .wr_off  (wr_off),
    .wr_tag  (q_tag),
    .wr_line (mem_rdata),
    .wr_word (wr_word)
  );

  assign hit = arr_valid && (arr_tag == in_tag);

  // Word-granular views of the cached line and of the incoming memory line.
  logic [WORD_SIZE-1:0] arr_words  [LINE_WORDS];
  logic [WORD_SIZE-1:0] fill_words [LINE_WORDS];
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_view
      assign arr_words[gi]  = arr_line[gi*WORD_SIZE +: WORD_SIZE];
      assign fill_words[gi] = mem_rdata[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  // Next-state logic and array write control; write wins over read in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    word_d  = word_q;
    wr_mode = ARR_WR_NONE;
    wr_idx  = q_idx;
    wr_off  = q_off;
    wr_word = data_q;
    case (state_q)
      ICACHE_IDLE: begin
        if (i_writeM) begin
          addr_d  = i_address;
          data_d  = i_data;
          rd_d    = 1'b0;
          state_d = ICACHE_WRITE;
          if (hit) begin
            wr_mode = ARR_WR_WORD;
            wr_idx  = in_idx;
            wr_off  = in_off;
            wr_word = i_data;
          end
        end else if (i_readM) begin
          addr_d = i_address;
          rd_d   = 1'b1;
          if (hit) begin
            word_d  = arr_words[in_off];
            state_d = ICACHE_RESP;
          end else begin
            state_d = ICACHE_FILL;
          end
        end
      end
      ICACHE_FILL: begin
        if (mem_ready) begin
          wr_mode = ARR_WR_LINE;
          word_d  = fill_words[q_off];
          state_d = ICACHE_RESP;
        end
      end
      ICACHE_WRITE: begin
        if (mem_ready) state_d = ICACHE_RESP;
      end
      ICACHE_RESP: state_d = ICACHE_IDLE;
      default:     state_d = ICACHE_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ICACHE_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      word_q  <= word_d;
    end
  end

  // Bus outputs decoded purely from state so reset drops them at once.
  always_comb begin
    i_ready     = (state_q == ICACHE_RESP);
    mem_read    = (state_q == ICACHE_FILL);
    mem_write   = (state_q == ICACHE_WRITE);
    mem_address = '0;
    mem_wdata   = '0;
    if (state_q == ICACHE_FILL) begin
      mem_address = {addr_q[WORD_SIZE-1:OFF], {OFF{1'b0}}};
    end else if (state_q == ICACHE_WRITE) begin
      mem_address = addr_q;
      mem_wdata   = data_q;
    end
  end

  assign i_data = (state_q == ICACHE_RESP && rd_q) ? word_q : {WORD_SIZE{1'bz}};

`ifdef ICACHE_STATS_EN
  logic [WORD_SIZE-1:0] num_hit_q, num_hit_d;
  logic [WORD_SIZE-1:0] num_miss_q, num_miss_d;

  // A hit is an IDLE->RESP transition, a miss is any entry into FILL.
  always_comb begin
    num_hit_d  = num_hit_q;
    num_miss_d = num_miss_q;
    if (state_q == ICACHE_IDLE && state_d == ICACHE_RESP) num_hit_d  = num_hit_q + WORD_SIZE'(1);
    if (state_q == ICACHE_IDLE && state_d == ICACHE_FILL) num_miss_d = num_miss_q + WORD_SIZE'(1);
  end

  // Statistics counters, wrapping naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_hit_q  <= '0;
      num_miss_q <= '0;
    end else begin
      num_hit_q  <= num_hit_d;
      num_miss_q <= num_miss_d;
    end
  end

  assign num_hit  = num_hit_q;
  assign num_miss = num_miss_q;
`endif

endmodule
